full_adder_nand: RTL and testbench
==================================

Name: full_adder_nand

Overview:
- Full adder built exclusively from 2-input NAND gates, with a registered output stage.
- Parameterisable as a ripple-carry chain of NAND full-adder cells; default configuration is a single-bit full adder.
- Used as a gate-level arithmetic leaf in lab/datapath designs where a NAND-only implementation is mandated.

Parameters:
- WIDTH, 1, number of bits in operands a/b and sum s; carry ripples LSB to MSB.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- a  input  WIDTH  addend operand
- b  input  WIDTH  addend operand
- cin  input  1  carry into bit 0
- s  output  WIDTH  registered sum
- cout  output  1  registered carry out of MSB

Behaviour:
- Each bit i is one NAND cell of exactly nine 2-input NANDs, with c0 = cin:
  - n1 = NAND(a[i], b[i])
  - n2 = NAND(a[i], n1)
  - n3 = NAND(b[i], n1)
  - x = NAND(n2, n3), which equals a XOR b
  - n5 = NAND(x, c[i])
  - n6 = NAND(x, n5)
  - n7 = NAND(c[i], n5)
  - sum[i] = NAND(n6, n7)
  - c[i+1] = NAND(n5, n1)
- No AND/OR/XOR operators and no '+' in the adder datapath. Only NAND, whether via primitive or ~(p&q).
- Combinational result: {c[WIDTH], sum} equals a + b + cin, computed as a (WIDTH+1)-bit unsigned sum.
- Output register, evaluated on each rising clk edge:
  - rst=1: s <= 0 and cout <= 0, regardless of inputs.
  - rst=0: s <= sum and cout <= c[WIDTH].
- Latency: exactly 1 cycle. Inputs presented before edge k appear on s/cout after edge k.
- Outputs change only on the clock edge. Input changes between edges have no effect on the outputs until the next edge.
- Reset:
  - Reset values: s = 0, cout = 0.
  - Reset asserted mid-stream clears the outputs at that edge.
  - The first edge after deassertion captures the current inputs; there is no warm-up cycle.
- Before the first clock edge, the outputs are X. Benches must reset first.
- Overflow: a carry out of the MSB is reported on cout only. There is no wrap flag.
- Maximum operands: a = b = all-ones with cin = 1 gives s = all-ones and cout = 1.
- No handshake: a new result is produced every cycle.

Optional Feature:
- Macro: FULL_ADDER_NAND_SELFCHECK_EN.
- When defined:
  - Adds output port err (1 bit, registered).
  - Each cycle, err <= ({c[WIDTH], sum} != a + b + cin). The reference sum here uses a behavioural '+', allowed only in this checker.
  - err resets to 0 under rst.
  - Simulation-only $error is issued when err goes high.
- When undefined:
  - No err port, no behavioural adder, no extra logic.
  - s/cout behaviour is identical in both builds.

Test Plan:
- Reset: set rst=1 with a=1, b=1, cin=1 and apply one edge -> s=0, cout=0. Deassert rst and apply one edge -> s=1, cout=1.
- WIDTH=1 exhaustive truth table: apply all 8 input combinations in order 000..111, one per cycle -> (s,cout) = 00, 10, 10, 01, 10, 01, 01, 11 on the following edge in turn.
- Latency check: change the inputs just after an edge -> outputs hold their old value until the next edge, then update.
- Reset mid-stream: feed a=1, b=0, cin=0 and assert rst for one edge -> s=0, cout=0. Next edge with rst=0 -> s=1, cout=0.
- WIDTH=4: a=4'hF, b=4'h1, cin=0 -> s=4'h0, cout=1. Then a=4'h5, b=4'hA, cin=1 -> s=4'h0, cout=1. Then a=4'h3, b=4'h4, cin=0 -> s=4'h7, cout=0.
- With FULL_ADDER_NAND_SELFCHECK_EN defined: random vectors for 1000 cycles at WIDTH=1 and WIDTH=8 -> err stays 0 throughout.

Source files
------------

// File: rtl/full_adder_nand.sv
// full_adder_nand: ripple-carry adder of 9-NAND cells with a registered sum/carry stage.
// Define FULL_ADDER_NAND_SELFCHECK_EN to add a registered err flag checked against a behavioural sum.
module full_adder_nand #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef FULL_ADDER_NAND_SELFCHECK_EN
    ,
    output logic             err
`endif
);
    function automatic logic nand2(input logic p, input logic q);
        return ~(p & q);
    endfunction

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s_d, s_q;
    logic             cout_d, cout_q;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic n1, n2, n3, x, n5, n6, n7;
        assign n1       = nand2(a[i], b[i]);
        assign n2       = nand2(a[i], n1);
        assign n3       = nand2(b[i], n1);
        assign x        = nand2(n2, n3);
        assign n5       = nand2(x, c[i]);
        assign n6       = nand2(x, n5);
        assign n7       = nand2(c[i], n5);
        assign sum[i]   = nand2(n6, n7);
        assign c[i+1]   = nand2(n5, n1);
    end

    assign s_d    = sum;
    assign cout_d = c[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign s    = s_q;
    assign cout = cout_q;

`ifdef FULL_ADDER_NAND_SELFCHECK_EN
    logic [WIDTH:0] ref_sum;
    logic           err_d, err_q;

    assign ref_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign err_d   = {c[WIDTH], sum} != ref_sum;

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && err_d && !err_q) $error("full_adder_nand: NAND datapath disagrees with reference sum");
    end
`endif
`endif
endmodule

// File: tb/tb_full_adder_nand.sv
// tb_full_adder_nand: scoreboarded random/directed bench for 1-bit and 4-bit instances.
module tb_full_adder_nand;
    logic       clk = 1'b0;
    logic       rst;
    logic [0:0] a1, b1, s1;
    logic       c1, co1;
    logic [3:0] a4, b4, s4;
    logic       c4, co4;
`ifdef FULL_ADDER_NAND_SELFCHECK_EN
    logic       err1, err4;
`endif

    int tests = 0;
    int fails = 0;

    logic [1:0] q1[$];
    logic [4:0] q4[$];
    logic [1:0] last1;
    logic [4:0] last4;
    bit         have_last = 0;

    always #5 clk = ~clk;

    full_adder_nand #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1), .s(s1), .cout(co1)
`ifdef FULL_ADDER_NAND_SELFCHECK_EN
        , .err(err1)
`endif
    );

    full_adder_nand #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(c4), .s(s4), .cout(co4)
`ifdef FULL_ADDER_NAND_SELFCHECK_EN
        , .err(err4)
`endif
    );

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer addition, zero while reset is applied.
    function automatic logic [4:0] model(input logic r, input int x, input int y, input int z);
        int t;
        t = r ? 0 : x + y + z;
        return t[4:0];
    endfunction

    // Drives one cycle of inputs, checks outputs still hold the previous result,
    // then pushes the expected response captured at the coming edge.
    task automatic step(input logic r, input logic x1, input logic y1, input logic z1,
                        input logic [3:0] x4, input logic [3:0] y4, input logic z4);
        logic [4:0] e1, e4;
        rst = r; a1 = x1; b1 = y1; c1 = z1; a4 = x4; b4 = y4; c4 = z4;
        #2;
        if (have_last) begin
            chk("hold_w1", {3'b0, co1, s1}, {3'b0, last1});
            chk("hold_w4", {co4, s4}, last4);
        end
        @(posedge clk);
        e1 = model(r, int'(x1), int'(y1), int'(z1));
        e4 = model(r, int'(x4), int'(y4), int'(z4));
        q1.push_back(e1[1:0]);
        q4.push_back(e4);
        last1 = e1[1:0];
        last4 = e4;
        have_last = 1;
        #1;
    endtask

    always @(negedge clk) begin
        if (q1.size() != 0) chk("out_w1", {3'b0, co1, s1}, {3'b0, q1.pop_front()});
        if (q4.size() != 0) chk("out_w4", {co4, s4}, q4.pop_front());
`ifdef FULL_ADDER_NAND_SELFCHECK_EN
        if (have_last) begin
            chk("err_w1", {4'b0, err1}, 5'd0);
            chk("err_w4", {4'b0, err4}, 5'd0);
        end
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] v;
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'h1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'h1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            step(1'b0, v[2], v[1], v[0], 4'(i), 4'(7 - i), v[0]);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h9, 4'h9, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h9, 4'h9, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h9, 4'h9, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h5, 4'hA, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 4'h4, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 19) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom), 1'($urandom));
        @(negedge clk);
        #1;
        chk("queue_drained", 5'(q1.size() + q4.size()), 5'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
